// File: rtl/bsg_wormhole_router_input_control.sv
// rtl/bsg_wormhole_router_input_control.sv - wormhole router per-input header decode and packet steering
// Optional protocol checker enabled by defining BSG_WH_INPUT_CTRL_ERR_EN.
module bsg_wormhole_router_input_control #(
  parameter int output_dirs_p  = 5,
  parameter int x_cord_width_p = 4,
  parameter int y_cord_width_p = 4,
  parameter int len_width_p    = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [x_cord_width_p-1:0] my_x_i,
  input  logic [y_cord_width_p-1:0] my_y_i,
  input  logic                      fifo_v_i,
  input  logic [x_cord_width_p-1:0] dest_x_i,
  input  logic [y_cord_width_p-1:0] dest_y_i,
  input  logic [len_width_p-1:0]    len_i,
  output logic                      fifo_yumi_o,
  output logic [output_dirs_p-1:0]  reqs_o,
  output logic [output_dirs_p-1:0]  valid_o,
  input  logic [output_dirs_p-1:0]  yumi_i,
  output logic [output_dirs_p-1:0]  release_o,
  output logic                      error_o
);

  typedef enum logic {HEAD, BODY} state_e;

  localparam int dir_p = 0;
  localparam int dir_w = 1;
  localparam int dir_e = 2;
  localparam int dir_n = 3;
  localparam int dir_s = 4;

  state_e                   state_r, state_n;
  logic [output_dirs_p-1:0] dest_r, dest_n;
  logic [len_width_p-1:0]   count_r, count_n;
  logic [output_dirs_p-1:0] release_r, release_n;
  logic [output_dirs_p-1:0] route;
  logic [output_dirs_p-1:0] reqs, valid;
  logic                     xfer;

  // XY dimension-ordered routing: resolve X fully before Y.
  always_comb begin
    route = '0;
    if (dest_x_i < my_x_i)      route[dir_w] = 1'b1;
    else if (dest_x_i > my_x_i) route[dir_e] = 1'b1;
    else if (dest_y_i < my_y_i) route[dir_n] = 1'b1;
    else if (dest_y_i > my_y_i) route[dir_s] = 1'b1;
    else                        route[dir_p] = 1'b1;
  end

  assign xfer = |yumi_i;

  always_comb begin
    state_n   = state_r;
    dest_n    = dest_r;
    count_n   = count_r;
    release_n = '0;
    reqs      = '0;
    valid     = '0;
    case (state_r)
      HEAD: begin
        reqs  = fifo_v_i ? route : '0;
        valid = reqs;
        if (xfer) begin
          if (len_i == '0) begin
            release_n = route;
          end else begin
            dest_n  = route;
            count_n = len_i;
            state_n = BODY;
          end
        end
      end
      BODY: begin
        valid = fifo_v_i ? dest_r : '0;
        if (xfer) begin
          count_n = count_r - len_width_p'(1);
          if (count_r == len_width_p'(1)) begin
            release_n = dest_r;
            state_n   = HEAD;
          end
        end
      end
      default: state_n = HEAD;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r   <= HEAD;
      dest_r    <= '0;
      count_r   <= '0;
      release_r <= '0;
    end else begin
      state_r   <= state_n;
      dest_r    <= dest_n;
      count_r   <= count_n;
      release_r <= release_n;
    end
  end

  // Outputs are forced quiet while reset is held, independent of inputs.
  assign reqs_o      = reset_n_i ? reqs  : '0;
  assign valid_o     = reset_n_i ? valid : '0;
  assign fifo_yumi_o = reset_n_i & xfer;
  assign release_o   = release_r;

`ifdef BSG_WH_INPUT_CTRL_ERR_EN
  logic error_r;
  logic bad_yumi;

  assign bad_yumi = !$onehot0(yumi_i) || ((yumi_i & ~valid) != '0);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)    error_r <= 1'b0;
    else if (bad_yumi) error_r <= 1'b1;
  end

  assign error_o = error_r;
`else
  assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_wormhole_router_input_control.sv
// tb/tb_bsg_wormhole_router_input_control.sv - directed vector bench for bsg_wormhole_router_input_control
module tb_bsg_wormhole_router_input_control;

`ifdef BSG_WH_INPUT_CTRL_ERR_EN
  localparam bit err_en = 1'b1;
`else
  localparam bit err_en = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic [3:0] my_x, my_y;
  logic       fifo_v;
  logic [3:0] dest_x, dest_y, len;
  logic       fifo_yumi;
  logic [4:0] reqs, valid, yumi, rel;
  logic       error;

  int n_checks = 0;
  int n_fail   = 0;

  bsg_wormhole_router_input_control #(
    .output_dirs_p(5), .x_cord_width_p(4), .y_cord_width_p(4), .len_width_p(4)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .my_x_i(my_x), .my_y_i(my_y),
    .fifo_v_i(fifo_v), .dest_x_i(dest_x), .dest_y_i(dest_y), .len_i(len),
    .fifo_yumi_o(fifo_yumi), .reqs_o(reqs), .valid_o(valid), .yumi_i(yumi),
    .release_o(rel), .error_o(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       v;
    logic [3:0] dx, dy, ln;
    logic [4:0] yu;
    logic [4:0] e_reqs, e_valid;
    logic       e_fy;
    logic [4:0] e_rel;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst_n, input logic v, input logic [3:0] dx, input logic [3:0] dy,
                     input logic [3:0] ln, input logic [4:0] yu, input logic [4:0] e_reqs,
                     input logic [4:0] e_valid, input logic e_fy, input logic [4:0] e_rel,
                     input logic e_err);
    vec_t r;
    r.rst_n = rst_n; r.v = v; r.dx = dx; r.dy = dy; r.ln = ln; r.yu = yu;
    r.e_reqs = e_reqs; r.e_valid = e_valid; r.e_fy = e_fy; r.e_rel = e_rel;
    r.e_err = e_err & err_en;
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [4:0] e_reqs, input logic [4:0] e_valid,
                         input logic e_fy, input logic [4:0] e_rel, input logic e_err);
    chk({tag, ".reqs"}, reqs, e_reqs);
    chk({tag, ".valid"}, valid, e_valid);
    chk({tag, ".fifo_yumi"}, {4'b0, fifo_yumi}, {4'b0, e_fy});
    chk({tag, ".release"}, rel, e_rel);
    chk({tag, ".error"}, {4'b0, error}, {4'b0, e_err});
  endtask

  task automatic drive(input logic rst_n, input logic v, input logic [3:0] dx, input logic [3:0] dy,
                       input logic [3:0] ln, input logic [4:0] yu);
    reset_n = rst_n; fifo_v = v; dest_x = dx; dest_y = dy; len = ln; yumi = yu;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    my_x = 4'd2; my_y = 4'd2;
    drive(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 5'b0);

    //  rst v   dx  dy  len  yumi      reqs      valid     fy  rel       err
    add(0, 1, 3, 2, 0, 5'b00100, 5'b00000, 5'b00000, 0, 5'b00000, 0);
    add(0, 1, 3, 2, 0, 5'b00100, 5'b00000, 5'b00000, 0, 5'b00000, 0);
    add(1, 1, 3, 2, 0, 5'b00000, 5'b00100, 5'b00100, 0, 5'b00000, 0);
    add(1, 1, 3, 2, 0, 5'b00100, 5'b00100, 5'b00100, 1, 5'b00000, 0);
    add(1, 1, 2, 2, 0, 5'b00000, 5'b00001, 5'b00001, 0, 5'b00100, 0);
    add(1, 1, 2, 2, 0, 5'b00001, 5'b00001, 5'b00001, 1, 5'b00000, 0);
    add(1, 0, 2, 2, 0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00001, 0);
    add(1, 0, 2, 2, 0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 0);
    // W packet, len 3; body rows carry unrelated header fields
    add(1, 1, 1, 2, 3, 5'b00010, 5'b00010, 5'b00010, 1, 5'b00000, 0);
    add(1, 1, 3, 2, 0, 5'b00010, 5'b00000, 5'b00010, 1, 5'b00000, 0);
    add(1, 1, 3, 2, 0, 5'b00010, 5'b00000, 5'b00010, 1, 5'b00000, 0);
    add(1, 1, 3, 2, 0, 5'b00010, 5'b00000, 5'b00010, 1, 5'b00000, 0);
    add(1, 0, 3, 2, 0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00010, 0);
    add(1, 0, 3, 2, 0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 0);
    // S packet, len 2, with a 3-cycle stall between body flits
    add(1, 1, 2, 5, 2, 5'b10000, 5'b10000, 5'b10000, 1, 5'b00000, 0);
    add(1, 1, 0, 0, 0, 5'b10000, 5'b00000, 5'b10000, 1, 5'b00000, 0);
    add(1, 0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 0);
    add(1, 0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 0);
    add(1, 0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 0);
    add(1, 1, 0, 0, 0, 5'b10000, 5'b00000, 5'b10000, 1, 5'b00000, 0);
    add(1, 0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b10000, 0);
    // N tail then N header in the release cycle, header waits for grant
    add(1, 1, 2, 0, 1, 5'b01000, 5'b01000, 5'b01000, 1, 5'b00000, 0);
    add(1, 1, 2, 0, 0, 5'b01000, 5'b00000, 5'b01000, 1, 5'b00000, 0);
    add(1, 1, 2, 0, 0, 5'b00000, 5'b01000, 5'b01000, 0, 5'b01000, 0);
    add(1, 1, 2, 0, 0, 5'b00000, 5'b01000, 5'b01000, 0, 5'b00000, 0);
    add(1, 1, 2, 0, 0, 5'b01000, 5'b01000, 5'b01000, 1, 5'b00000, 0);
    add(1, 0, 2, 0, 0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b01000, 0);
    // non-one-hot yumi, then yumi on a non-valid lane
    add(1, 1, 3, 2, 0, 5'b00011, 5'b00100, 5'b00100, 1, 5'b00000, 0);
    add(1, 0, 3, 2, 0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00100, 1);
    add(1, 0, 3, 2, 0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 1);
    add(0, 0, 3, 2, 0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 0);
    add(1, 0, 2, 2, 0, 5'b00001, 5'b00000, 5'b00000, 1, 5'b00000, 0);
    add(1, 0, 2, 2, 0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00001, 1);
    add(0, 0, 2, 2, 0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 0);
    add(1, 0, 2, 2, 0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 0);

    #1;
    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].v, vecs[i].dx, vecs[i].dy, vecs[i].ln, vecs[i].yu);
      #3;
      chk_all($sformatf("row%0d", i), vecs[i].e_reqs, vecs[i].e_valid, vecs[i].e_fy,
              vecs[i].e_rel, vecs[i].e_err);
      step();
    end

    // Maximum length: header plus 15 body flits to W
    drive(1'b1, 1'b1, 4'd0, 4'd2, 4'd15, 5'b00010);
    #3 chk_all("max_head", 5'b00010, 5'b00010, 1'b1, 5'b00000, 1'b0);
    step();
    for (int k = 0; k < 15; k++) begin
      drive(1'b1, 1'b1, 4'd2, 4'd2, 4'd0, 5'b00010);
      #3 chk_all($sformatf("max_body%0d", k), 5'b00000, 5'b00010, 1'b1, 5'b00000, 1'b0);
      step();
    end
    drive(1'b1, 1'b0, 4'd2, 4'd2, 4'd0, 5'b00000);
    #3 chk_all("max_release", 5'b00000, 5'b00000, 1'b0, 5'b00010, 1'b0);
    step();
    #3 chk_all("max_release_clear", 5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b0);
    step();

    // Reset mid-packet abandons without release; next flit is treated as a header
    drive(1'b1, 1'b1, 4'd3, 4'd2, 4'd3, 5'b00100);
    #3 chk_all("abn_head", 5'b00100, 5'b00100, 1'b1, 5'b00000, 1'b0);
    step();
    drive(1'b1, 1'b1, 4'd3, 4'd2, 4'd0, 5'b00100);
    #3 chk_all("abn_body", 5'b00000, 5'b00100, 1'b1, 5'b00000, 1'b0);
    step();
    drive(1'b0, 1'b1, 4'd3, 4'd2, 4'd0, 5'b00000);
    #3 chk_all("abn_reset", 5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b0);
    step();
    drive(1'b1, 1'b1, 4'd3, 4'd2, 4'd0, 5'b00000);
    #3 chk_all("abn_after", 5'b00100, 5'b00100, 1'b0, 5'b00000, 1'b0);
    step();
    drive(1'b1, 1'b0, 4'd3, 4'd2, 4'd0, 5'b00000);
    #3 chk_all("abn_norel", 5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
